// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry defaults, colour layout, sprite motion helpers and debounce states
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;
  localparam rgb_t BLACK = '{r: 3'd0, g: 3'd0, b: 2'd0};
  localparam rgb_t BLUE  = '{r: 3'd0, g: 3'd0, b: 2'd3};
  typedef enum logic {DIR_POS, DIR_NEG} dir_t;
  typedef struct packed {
    logic [9:0] pos;
    dir_t       dir;
  } axis_t;
  typedef enum logic [1:0] {DB_IDLE, DB_CONFIRM_HIGH, DB_PRESSED, DB_CONFIRM_LOW} db_state_t;
  function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo, input logic [10:0] w);
    return (v >= lo) && (v < lo + w);
  endfunction
  // One frame of bounce on one axis; clamps to [0, lim] and reverses at either wall.
  function automatic axis_t axis_step(input axis_t a, input logic [10:0] lim, input logic [10:0] step);
    logic [10:0] p;
    p = {1'b0, a.pos};
    axis_step = a;
    if (a.dir == DIR_POS) begin
      axis_step.pos = (p + step >= lim) ? 10'(lim) : 10'(p + step);
      axis_step.dir = (p + step >= lim) ? DIR_NEG : DIR_POS;
    end else begin
      axis_step.pos = (p <= step) ? 10'd0 : 10'(p - step);
      axis_step.dir = (p <= step) ? DIR_POS : DIR_NEG;
    end
  endfunction
endpackage

// File: rtl/sprite_pixel_gen_if.sv
// sprite_pixel_gen_if: pixel request / colour reply bus between signal_gen and a colour source
interface sprite_pixel_gen_if;
  logic       req;
  logic [9:0] col;
  logic [9:0] row;
  logic [7:0] switches;
  logic [7:0] next_color;
  modport master (output req, col, row, switches, input next_color);
  modport slave  (input req, col, row, switches, output next_color);
endinterface

// File: rtl/button_debounce.sv
// button_debounce: synchronises a raw button and emits one pulse per debounced press
module button_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  db_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] sync_q;
  logic level, differ, done;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DB_IDLE;
      cnt_q   <= '0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= {sync_q[0], btn_raw};
    end
  end
  // The counter runs over consecutive differing cycles; the state-entry cycle counts as the first.
  always_comb begin
    level   = (state_q == DB_PRESSED) || (state_q == DB_CONFIRM_LOW);
    differ  = sync_q[1] ^ level;
    done    = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d   = (differ && !done) ? cnt_q + CW'(1) : '0;
    state_d = state_q;
    case (state_q)
      DB_IDLE:         state_d = differ ? DB_CONFIRM_HIGH : DB_IDLE;
      DB_CONFIRM_HIGH: state_d = !differ ? DB_IDLE : done ? DB_PRESSED : DB_CONFIRM_HIGH;
      DB_PRESSED:      state_d = differ ? DB_CONFIRM_LOW : DB_PRESSED;
      DB_CONFIRM_LOW:  state_d = !differ ? DB_PRESSED : done ? DB_IDLE : DB_CONFIRM_LOW;
      default:         state_d = DB_IDLE;
    endcase
  end
  always_comb press_pulse = (state_q == DB_CONFIRM_HIGH) && differ && done;
endmodule

// File: rtl/sprite_pixel_gen.sv
// sprite_pixel_gen: colour source drawing one bouncing square sprite over a solid background
module sprite_pixel_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE        = H_ACTIVE_DEF,
  parameter int   V_ACTIVE        = V_ACTIVE_DEF,
  parameter int   SPRITE_W        = 32,
  parameter int   SPRITE_H        = 32,
  parameter int   STEP            = 2,
  parameter rgb_t BG_COLOR        = BLUE,
  parameter int   DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pause_button,
  sprite_pixel_gen_if.slave bus
);
  localparam logic [10:0] XMAX = 11'(H_ACTIVE - SPRITE_W);
  localparam logic [10:0] YMAX = 11'(V_ACTIVE - SPRITE_H);
  rgb_t  color_q, color_d;
  axis_t sprite_x_q, sprite_x_d, sprite_y_q, sprite_y_d;
  logic  frame_tick_q, frame_tick_d, paused_q, paused_d;
  logic  press_pulse, in_area, on_sprite, move;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(pause_button),
    .press_pulse(press_pulse)
  );
  // Motion reads paused_q, so a press landing on the tick cycle only affects later frames.
  always_comb begin
    in_area      = ({1'b0, bus.col} < 11'(H_ACTIVE)) && ({1'b0, bus.row} < 11'(V_ACTIVE));
    on_sprite    = in_span({1'b0, bus.col}, {1'b0, sprite_x_q.pos}, 11'(SPRITE_W)) &&
                   in_span({1'b0, bus.row}, {1'b0, sprite_y_q.pos}, 11'(SPRITE_H));
    color_d      = !bus.req ? color_q : !in_area ? BLACK : on_sprite ? rgb_t'(bus.switches) : BG_COLOR;
    frame_tick_d = bus.req && (bus.col == 10'(H_ACTIVE - 1)) && (bus.row == 10'(V_ACTIVE - 1));
    paused_d     = paused_q ^ press_pulse;
    move         = frame_tick_q && !paused_q;
    sprite_x_d   = move ? axis_step(sprite_x_q, XMAX, 11'(STEP)) : sprite_x_q;
    sprite_y_d   = move ? axis_step(sprite_y_q, YMAX, 11'(STEP)) : sprite_y_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_q      <= BLACK;
      sprite_x_q   <= '{pos: 10'd0, dir: DIR_POS};
      sprite_y_q   <= '{pos: 10'd0, dir: DIR_POS};
      frame_tick_q <= 1'b0;
      paused_q     <= 1'b0;
    end else begin
      color_q      <= color_d;
      sprite_x_q   <= sprite_x_d;
      sprite_y_q   <= sprite_y_d;
      frame_tick_q <= frame_tick_d;
      paused_q     <= paused_d;
    end
  end
  assign bus.next_color = color_q;
endmodule

// File: tb/tb_sprite_pixel_gen.sv
// tb_sprite_pixel_gen: directed self-checking bench for sprite_pixel_gen
module tb_sprite_pixel_gen;
  import vga_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause_button = 1'b0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  sprite_pixel_gen_if bus ();
  sprite_pixel_gen #(.DEBOUNCE_CYCLES(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pause_button(pause_button),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (dut.u_db.press_pulse) pulses <= pulses + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pix(input logic [9:0] c, input logic [9:0] r, input logic [7:0] sw);
    @(negedge clk);
    bus.req = 1'b1; bus.col = c; bus.row = r; bus.switches = sw;
    @(negedge clk);
    bus.req = 1'b0;
  endtask
  task automatic do_tick();
    @(negedge clk);
    bus.req = 1'b1; bus.col = 10'd639; bus.row = 10'd479;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    bus.req = 1'b0; bus.col = '0; bus.row = '0; bus.switches = '0;
    repeat (3) @(negedge clk);
    chk("rst_color", bus.next_color, 8'h00);
    chk("rst_x", dut.sprite_x_q.pos, 0);
    chk("rst_y", dut.sprite_y_q.pos, 0);
    chk("rst_tick", dut.frame_tick_q, 0);
    chk("rst_paused", dut.paused_q, 0);
    rst_n = 1'b1;
    pix(10'd5, 10'd5, 8'hE0);   chk("pix_sprite", bus.next_color, 8'hE0);
    pix(10'd100, 10'd5, 8'hE0); chk("pix_bg", bus.next_color, 8'h03);
    pix(10'd700, 10'd5, 8'hE0); chk("pix_offscreen", bus.next_color, 8'h00);
    pix(10'd5, 10'd480, 8'hE0); chk("pix_below", bus.next_color, 8'h00);
    pix(10'd31, 10'd31, 8'h5A); chk("pix_corner_in", bus.next_color, 8'h5A);
    pix(10'd32, 10'd31, 8'h5A); chk("pix_edge_out", bus.next_color, 8'h03);
    pix(10'd5, 10'd5, 8'hE0);
    bus.col = 10'd100;
    repeat (10) @(negedge clk);
    chk("hold_req0", bus.next_color, 8'hE0);
    chk("no_tick_yet", dut.frame_tick_q, 0);
    @(negedge clk);
    bus.req = 1'b1; bus.col = 10'd639; bus.row = 10'd479;
    @(negedge clk);
    bus.req = 1'b0;
    chk("tick_high", dut.frame_tick_q, 1);
    chk("tick_x_before", dut.sprite_x_q.pos, 0);
    @(negedge clk);
    chk("tick_one_clk", dut.frame_tick_q, 0);
    chk("move1_x", dut.sprite_x_q.pos, 2);
    chk("move1_y", dut.sprite_y_q.pos, 2);
    repeat (9) do_tick();
    chk("move10_x", dut.sprite_x_q.pos, 20);
    chk("move10_y", dut.sprite_y_q.pos, 20);
    repeat (294) do_tick();
    chk("xmax_pos", dut.sprite_x_q.pos, 608);
    chk("xmax_dir", dut.sprite_x_q.dir, DIR_NEG);
    chk("y_t304", dut.sprite_y_q.pos, 288);
    chk("ydir_t304", dut.sprite_y_q.dir, DIR_NEG);
    do_tick();
    chk("x_back", dut.sprite_x_q.pos, 606);
    repeat (302) do_tick();
    chk("x_near0", dut.sprite_x_q.pos, 2);
    do_tick();
    chk("xmin_pos", dut.sprite_x_q.pos, 0);
    chk("xmin_dir", dut.sprite_x_q.dir, DIR_POS);
    chk("y_t608", dut.sprite_y_q.pos, 320);
    chk("ydir_t608", dut.sprite_y_q.dir, DIR_POS);
    chk("no_pulse_idle", pulses, 0);
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      pause_button = ~i[0];
      repeat (3) @(negedge clk);
    end
    chk("bounce_no_pulse", pulses - p0, 0);
    pause_button = 1'b1;
    repeat (12) @(negedge clk);
    pause_button = 1'b0;
    repeat (20) @(negedge clk);
    chk("one_pulse", pulses - p0, 1);
    chk("paused", dut.paused_q, 1);
    repeat (3) do_tick();
    chk("paused_x", dut.sprite_x_q.pos, 0);
    chk("paused_y", dut.sprite_y_q.pos, 320);
    pix(10'd10, 10'd330, 8'h1C); chk("pix_moved_in", bus.next_color, 8'h1C);
    pix(10'd10, 10'd10, 8'h1C);  chk("pix_moved_out", bus.next_color, 8'h03);
    pix(10'd10, 10'd330, 8'h1C);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_color", bus.next_color, 8'h00);
    chk("arst_x", dut.sprite_x_q.pos, 0);
    chk("arst_y", dut.sprite_y_q.pos, 0);
    chk("arst_paused", dut.paused_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pix(10'd639, 10'd478, 8'h1C); chk("no_tick_row", dut.frame_tick_q, 0);
    pix(10'd638, 10'd479, 8'h1C); chk("no_tick_col", dut.frame_tick_q, 0);
    @(negedge clk);
    bus.req = 1'b1; bus.col = 10'd639; bus.row = 10'd479;
    @(negedge clk);
    bus.req = 1'b0;
    chk("tick_after_rst", dut.frame_tick_q, 1);
    @(negedge clk);
    chk("move_after_rst", dut.sprite_x_q.pos, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
